// File: rtl/alu_mdu.sv
// RV32I ALU plus M-extension execute unit. Base ops complete in one cycle.
// Multiply and divide iterate one bit per cycle on operand magnitudes.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] d0,
    input  logic [XLEN-1:0] d1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_mop;
    logic              r_neg;
    logic [XLEN-1:0]   r_y;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvs;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds its payload stable until that edge.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign y         = r_y;

    logic            w_m, w_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic            w_dz, w_ovf, w_neg;
    logic [SHW-1:0]  w_sh;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_special, w_base;

    assign w_m       = op[4] & ~op[3];
    assign w_div     = w_m & op[2];
    assign w_a_sgn   = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign w_b_sgn   = op[2] ? ~op[0] : ~op[1];
    assign w_a_neg   = w_a_sgn & d0[XLEN-1];
    assign w_b_neg   = w_b_sgn & d1[XLEN-1];
    assign w_a_mag   = w_a_neg ? -d0 : d0;
    assign w_b_mag   = w_b_neg ? -d1 : d1;
    // Remainder follows the dividend's sign; quotient and product follow the xor.
    assign w_neg     = (op[2] & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_dz      = (d1 == '0);
    assign w_ovf     = ~op[0] & (d0 == MINV) & (d1 == '1);
    assign w_special = w_dz ? (op[1] ? d0 : '1) : (op[1] ? '0 : d0);
    assign w_sh      = d1[SHW-1:0];

    always_comb begin
        w_base = '0;
        case (op)
            5'b00000: w_base = d0 + d1;
            5'b00001: w_base = d0 - d1;
            5'b00010: w_base = d0 & d1;
            5'b00011: w_base = d0 | d1;
            5'b00100: w_base = d0 ^ d1;
            5'b00101: w_base = {{(XLEN-1){1'b0}}, $signed(d0) < $signed(d1)};
            5'b00110: w_base = {{(XLEN-1){1'b0}}, d0 < d1};
            5'b00111: w_base = d0 << w_sh;
            5'b01000: w_base = d0 >> w_sh;
            5'b01001: w_base = $signed(d0) >>> w_sh;
            default:  w_base = '0;
        endcase
    end

    logic [2*XLEN-1:0] w_acc_nx, w_prod;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_rem_sh, w_rem_nx, w_quo_nx, w_q_fin, w_r_fin, w_fin;

    assign w_acc_nx = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod   = r_neg ? -w_acc_nx : w_acc_nx;
    // Restoring step: a borrow out of the top bit means the trial subtract failed.
    assign w_rem_sh = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_diff   = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};
    assign w_rem_nx = w_diff[XLEN] ? w_rem_sh : w_diff[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    assign w_q_fin  = r_neg ? -w_quo_nx : w_quo_nx;
    assign w_r_fin  = r_neg ? -w_rem_nx : w_rem_nx;

    always_comb begin
        w_fin = '0;
        case (r_mop)
            3'b000:         w_fin = w_prod[XLEN-1:0];
            3'b100, 3'b101: w_fin = w_q_fin;
            3'b110, 3'b111: w_fin = w_r_fin;
            default:        w_fin = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mop    <= '0;
            r_neg    <= 1'b0;
            r_y      <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    if (!w_m) begin
                        r_y     <= w_base;
                        r_state <= DONE;
                    end else if (w_div && (w_dz || w_ovf)) begin
                        r_y     <= w_special;
                        r_state <= DONE;
                    end else begin
                        r_mop    <= op[2:0];
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_dvs    <= w_b_mag;
                        r_cnt    <= CW'(XLEN);
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc    <= w_acc_nx;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_nx;
                    r_quo    <= w_quo_nx;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_y     <= w_fin;
                        r_state <= DONE;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed and random checks of alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      op = '0;
    logic [XLEN-1:0] d0 = '0;
    logic [XLEN-1:0] d1 = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] y;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .d0(d0), .d1(d1),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_y(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic signed [31:0] s = a;
        logic [63:0] p;
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd6:  return (a < b) ? 32'd1 : 32'd0;
            5'd7:  return a << b[4:0];
            5'd8:  return a >> b[4:0];
            5'd9:  return s >>> b[4:0];
            5'd16: begin p = sa * sb; return p[31:0]; end
            5'd17: begin p = sa * sb; return p[63:32]; end
            5'd18: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            5'd19: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            5'd20: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Clock edges after the accepting edge until out_valid is visible.
    function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < 5'd16 || o > 5'd23) return 0;
        if (o >= 5'd20 && b == 0) return 0;
        if ((o == 5'd20 || o == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return XLEN;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; d0 = a; d1 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 5'($urandom); d0 = $urandom; d1 = $urandom;
    endtask

    task automatic wait_valid(output int lat, output int ir_high);
        lat = 0;
        ir_high = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_high++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int ir_high;
        exp_q.push_back(ref_y(o, a, b));
        issue(o, a, b);
        wait_valid(lat, ir_high);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(ref_lat(o, a, b)));
        chk({tag, "_y"}, y, exp_q.pop_front());
        if (lat > 0) chk({tag, "_inready_busy"}, 32'(ir_high), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int lat;
        int ir_high;
        int good;
        int seen;
        logic [4:0] codes[20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                  5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                                  5'd12, 5'd30};

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_y", y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1);
        run_op("sra", 5'd9, 32'h8000_0000, 32'h24);
        run_op("sltu", 5'd6, 32'd1, 32'hFFFF_FFFF);
        run_op("mul", 5'd16, 32'hFFFF_FFFE, 32'd3);
        run_op("mulh", 5'd17, 32'hFFFF_FFFE, 32'd3);
        run_op("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'd2);
        run_op("div", 5'd20, 32'hFFFF_FFF9, 32'd2);
        run_op("rem", 5'd22, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_dz", 5'd21, 32'd7, 32'd0);
        run_op("remu_dz", 5'd23, 32'd7, 32'd0);
        run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        exp_q.push_back(ref_y(5'd16, 32'd1234, 32'd5678));
        issue(5'd16, 32'd1234, 32'd5678);
        wait_valid(lat, ir_high);
        chk("bp_lat", 32'(lat), 32'd32);
        good = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && !in_ready && y === exp_q[0]) good++;
        end
        chk("bp_stable", 32'(good), 32'd5);
        chk("bp_y", y, exp_q.pop_front());
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {30'd0, in_ready, out_valid}, 32'd2);

        // Flush in the middle of a divide.
        issue(5'd20, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle", {29'd0, in_ready, out_valid, busy}, 32'd4);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        run_op("add_after_flush", 5'd0, 32'd2, 32'd3);

        // Flush on the accepting edge drops the op.
        @(negedge clk);
        op = 5'd0; d0 = 32'd9; d1 = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept", {29'd0, in_ready, out_valid, busy}, 32'd4);

        // Asynchronous reset while iterating.
        run_op("pre_rst_add", 5'd0, 32'h1234, 32'd1);
        issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_state", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'd8);
        chk("arst_y", y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mulhu_after_rst", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ops[2];
            logic [4:0] o;
            o = codes[$urandom_range(0, 19)];
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 5))
                    0: ops[k] = 32'd0;
                    1: ops[k] = 32'hFFFF_FFFF;
                    2: ops[k] = 32'h8000_0000;
                    3: ops[k] = 32'($urandom_range(0, 9));
                    default: ops[k] = $urandom;
                endcase
            end
            run_op($sformatf("rnd%0d_op%0d", n, o), o, ops[0], ops[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised execute unit that replaces the single-cycle combinational ALU in the EX stage. It keeps the full RV32I ALU op set and adds the RV M-extension: mul, mulh, mulhsu, mulhu, div, divu, rem and remu. Multiply and divide are iterative (one bit per cycle) to keep area and timing low. Operands enter and results leave through valid/ready handshakes, so the pipeline stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand/result width (≥8, power of two)
SHW, $clog2(XLEN), shift-amount width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any op in flight
in_valid  input  1  operands/op valid
in_ready  output  1  unit can accept (high only in IDLE)
op  input  5  operation code
d0  input  XLEN  operand A (rs1)
d1  input  XLEN  operand B (rs2/imm)
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
y  output  XLEN  result
busy  output  1  high in BUSY or DONE

Behaviour:
- Op codes, op[4]=0 (base): 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 slt (signed), 00110 sltu, 00111 sll, 01000 srl, 01001 sra. Shifts use d1[SHW-1:0] only.
- Op codes, op[4]=1 (M): 10000 mul (low XLEN), 10001 mulh (s×s), 10010 mulhsu (s×u), 10011 mulhu, 10100 div, 10101 divu, 10110 rem, 10111 remu. Any other code yields y=0 with base latency.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- Accept: handshake at edge E0 when in_valid && in_ready. Operands and op are registered; d0/d1 may change afterwards.
- Base ops and unknown codes: IDLE→DONE at E0; result registered. Latency 1.
- M ops: IDLE→BUSY at E0, with iteration counter = XLEN.
  - Each BUSY edge performs one iteration and decrements the counter.
  - The edge with counter==1 writes y and enters DONE, so out_valid rises after E_XLEN. Latency XLEN.
- Multiply: operands are sign- or magnitude-extended to 2·XLEN according to signedness; shift-add over XLEN steps. mul returns product[XLEN-1:0]; the mulh variants return product[2XLEN-1:XLEN].
- Divide: restoring, on magnitudes; signs fixed after the last step. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: no iteration; DONE at E0, latency 1. div/divu y = all-ones; rem/remu y = d0.
- Signed overflow (d0 = 1<<(XLEN-1), d1 = all-ones, div/rem): DONE at E0. div y = d0; rem y = 0.
- DONE: y and out_valid hold stable until out_ready. DONE && out_ready → IDLE at that edge, so y/out_valid are consumed in one cycle. No acceptance in DONE, so the minimum accept-to-accept spacing is 2 cycles for base ops.
- flush: highest priority over every other transition. Next edge → IDLE, out_valid=0, counter cleared, result discarded. If flush coincides with an accept, the op is dropped.
- Reset (asynchronous, any state, including mid-iteration): state=IDLE, out_valid=0, y=0, busy=0, counter=0, internal accumulators=0. in_ready=1 while rst_n=0 and after release.
- All arithmetic is modulo 2^XLEN except the 2·XLEN product register. Arithmetic must not produce X with X-free inputs.

Test Plan:
- Base ops, XLEN=32, out_ready=1: add 0x7FFFFFFF+1 → y=0x80000000, out_valid one cycle after accept. sra 0x80000000 by d1=0x24 (uses 4) → 0xF8000000. sltu 1 vs 0xFFFFFFFF → 1.
- Multiply: mul −2×3 → 0xFFFFFFFA. mulh same → 0xFFFFFFFF. mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. mulhsu 0xFFFFFFFF×2 → 0xFFFFFFFF. out_valid exactly 32 cycles after accept; in_ready low throughout.
- Divide: div −7/2 → 0xFFFFFFFD, rem → 0xFFFFFFFF. divu 7/0 → 0xFFFFFFFF, remu 7/0 → 7, latency 1. div 0x80000000/0xFFFFFFFF → 0x80000000, rem → 0.
- Backpressure: out_ready=0 for 5 cycles after a mul completes → y and out_valid stable, in_ready=0. out_ready=1 → IDLE next edge, in_ready=1.
- flush at iteration 10 of div → out_valid never rises, IDLE next edge. A following add 2+3 → y=5.
- Reset: rst_n low mid-BUSY (asynchronous, between edges) → out_valid=0, y=0, busy=0 immediately. After release, mulhu 0xFFFFFFFF×0xFFFFFFFF still → 0xFFFFFFFE.
